// File: rtl/esdi_cmd_serializer_if.sv
// Fabric command/response handshake plus the ESDI serial control pins.
// slave is the serializer's view; master is the fabric/drive side.
interface esdi_cmd_serializer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_data;
    logic        cmd_read_status;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_status;
    logic        rsp_parity_err;
    logic        rsp_timeout;
    logic        esdi_transfer_req;
    logic        esdi_command_data;
    logic        esdi_transfer_ack;
    logic        esdi_confstat_data;

    modport master (
        output cmd_valid, cmd_data, cmd_read_status, rsp_ready,
               esdi_transfer_ack, esdi_confstat_data,
        input  cmd_ready, rsp_valid, rsp_status, rsp_parity_err, rsp_timeout,
               esdi_transfer_req, esdi_command_data
    );

    modport slave (
        input  cmd_valid, cmd_data, cmd_read_status, rsp_ready,
               esdi_transfer_ack, esdi_confstat_data,
        output cmd_ready, rsp_valid, rsp_status, rsp_parity_err, rsp_timeout,
               esdi_transfer_req, esdi_command_data
    );
endinterface

// File: rtl/esdi_cmd_serializer.sv
// ESDI serial command engine: shifts a 17-bit odd-parity command frame out on the
// REQ/ACK handshake and optionally reads back a 17-bit status frame.
module esdi_cmd_serializer #(
    parameter int SETUP_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    esdi_cmd_serializer_if.slave bus
);

    localparam int CNT_MAX = (TIMEOUT_CYCLES > SETUP_CYCLES) ? TIMEOUT_CYCLES : SETUP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, C_SETUP, C_REQ, C_REL, S_REQ, S_REL, RESP
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [4:0]             bit_cnt_q, bit_cnt_d;
    logic [16:0]            frame_q, frame_d;
    logic [16:0]            stat_q, stat_d;
    logic                   rd_q, rd_d;
    logic [SYNC_STAGES-1:0] ack_sync_q, conf_sync_q;
    logic                   req_q, req_d;
    logic                   cdat_q, cdat_d;
    logic                   ready_q, ready_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [15:0]            rsp_status_q, rsp_status_d;
    logic                   rsp_perr_q, rsp_perr_d;
    logic                   rsp_to_q, rsp_to_d;
    logic                   ack_s, conf_s, timeout;

    assign ack_s  = ack_sync_q[SYNC_STAGES-1];
    assign conf_s = conf_sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        frame_d      = frame_q;
        stat_d       = stat_q;
        rd_d         = rd_q;
        rsp_status_d = rsp_status_q;
        rsp_perr_d   = rsp_perr_q;
        rsp_to_d     = rsp_to_q;
        timeout      = 1'b0;

        case (state_q)
            IDLE: begin
                if (ready_q && bus.cmd_valid) begin
                    frame_d   = {bus.cmd_data, ~^bus.cmd_data};
                    rd_d      = bus.cmd_read_status;
                    bit_cnt_d = '0;
                    state_d   = C_SETUP;
                end
            end
            C_SETUP: begin
                if (cnt_q == SETUP_LAST) state_d = C_REQ;
            end
            C_REQ: begin
                if (ack_s) state_d = C_REL;
                else if (cnt_q == TO_LAST) timeout = 1'b1;
            end
            C_REL: begin
                if (!ack_s) begin
                    if (bit_cnt_q != 5'd16) begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        frame_d   = {frame_q[15:0], 1'b0};
                        state_d   = C_SETUP;
                    end else begin
                        bit_cnt_d = '0;
                        stat_d    = '0;
                        state_d   = rd_q ? S_REQ : RESP;
                    end
                end else if (cnt_q == TO_LAST) begin
                    timeout = 1'b1;
                end
            end
            S_REQ: begin
                if (ack_s) begin
                    stat_d  = {stat_q[15:0], conf_s};
                    state_d = S_REL;
                end else if (cnt_q == TO_LAST) begin
                    timeout = 1'b1;
                end
            end
            S_REL: begin
                if (!ack_s) begin
                    if (bit_cnt_q != 5'd16) begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        state_d   = S_REQ;
                    end else begin
                        state_d = RESP;
                    end
                end else if (cnt_q == TO_LAST) begin
                    timeout = 1'b1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (timeout) state_d = RESP;

        // Response fields are captured once on RESP entry and cleared on hand-off.
        if (state_d == RESP && state_q != RESP) begin
            rsp_to_d     = timeout;
            rsp_status_d = (timeout || !rd_q) ? '0 : stat_d[16:1];
            rsp_perr_d   = (!timeout && rd_q) ? ~(^stat_d) : 1'b0;
        end else if (state_q == RESP && state_d == IDLE) begin
            rsp_to_d     = 1'b0;
            rsp_status_d = '0;
            rsp_perr_d   = 1'b0;
        end

        if (state_d != state_q)
            cnt_d = '0;
        else if (state_q inside {C_SETUP, C_REQ, C_REL, S_REQ, S_REL})
            cnt_d = cnt_q + CNT_W'(1);
        else
            cnt_d = '0;

        req_d       = (state_d inside {C_REQ, S_REQ});
        cdat_d      = (state_d inside {C_SETUP, C_REQ, C_REL}) ? frame_d[16] : 1'b0;
        ready_d     = (state_d == IDLE);
        rsp_valid_d = (state_d == RESP);
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_cnt_q    <= '0;
            frame_q      <= '0;
            stat_q       <= '0;
            rd_q         <= 1'b0;
            ack_sync_q   <= '0;
            conf_sync_q  <= '0;
            req_q        <= 1'b0;
            cdat_q       <= 1'b0;
            ready_q      <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_status_q <= '0;
            rsp_perr_q   <= 1'b0;
            rsp_to_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            frame_q      <= frame_d;
            stat_q       <= stat_d;
            rd_q         <= rd_d;
            ack_sync_q   <= {ack_sync_q[SYNC_STAGES-2:0], bus.esdi_transfer_ack};
            conf_sync_q  <= {conf_sync_q[SYNC_STAGES-2:0], bus.esdi_confstat_data};
            req_q        <= req_d;
            cdat_q       <= cdat_d;
            ready_q      <= ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_status_q <= rsp_status_d;
            rsp_perr_q   <= rsp_perr_d;
            rsp_to_q     <= rsp_to_d;
        end
    end

    assign bus.cmd_ready         = ready_q;
    assign bus.rsp_valid         = rsp_valid_q;
    assign bus.rsp_status        = rsp_status_q;
    assign bus.rsp_parity_err    = rsp_perr_q;
    assign bus.rsp_timeout       = rsp_to_q;
    assign bus.esdi_transfer_req = req_q;
    assign bus.esdi_command_data = cdat_q;

endmodule

// File: tb/tb_esdi_cmd_serializer.sv
// Directed bench for esdi_cmd_serializer: a task-based drive model answers each REQ
// with ACK a few cycles later and supplies status bits on CONFIG/STATUS DATA.
module tb_esdi_cmd_serializer;
    localparam int SETUP = 4;
    localparam int TO    = 50;
    localparam int SYNC  = 2;
    localparam int LIMIT = 200;

    logic aclk    = 1'b0;
    logic aresetn = 1'b0;

    esdi_cmd_serializer_if bus ();

    esdi_cmd_serializer #(
        .SETUP_CYCLES  (SETUP),
        .TIMEOUT_CYCLES(TO),
        .SYNC_STAGES   (SYNC)
    ) dut (
        .aclk   (aclk),
        .aresetn(aresetn),
        .bus    (bus.slave)
    );

    always #5 aclk = ~aclk;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   stable   = 0;
    logic last_data = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Counts consecutive idle-req cycles during which command_data has not changed.
    task automatic track_setup();
        if (bus.esdi_transfer_req === 1'b0) begin
            if (bus.esdi_command_data === last_data) stable++;
            else stable = 1;
            last_data = bus.esdi_command_data;
        end
    endtask

    task automatic wait_req(input logic lvl, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < LIMIT; i++) begin
            @(negedge aclk);
            track_setup();
            if (bus.esdi_transfer_req === lvl) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic send_cmd(input logic [15:0] w, input logic rd);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < LIMIT; i++) begin
            if (bus.cmd_ready === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge aclk);
        end
        bus.cmd_data        = w;
        bus.cmd_read_status = rd;
        bus.cmd_valid       = 1'b1;
        @(negedge aclk);
        bus.cmd_valid = 1'b0;
        track_setup();
        check("cmd_accept", {seen, bus.cmd_ready}, 2'b10);
    endtask

    task automatic xfer_bit(input logic conf, output logic b, output int st, output bit ok);
        bit ok1, ok2;
        ok = 1'b0;
        b  = 1'b0;
        wait_req(1'b1, ok1);
        st = stable;
        if (!ok1) return;
        b = bus.esdi_command_data;
        repeat (2) @(negedge aclk);
        bus.esdi_confstat_data = conf;
        bus.esdi_transfer_ack  = 1'b1;
        wait_req(1'b0, ok2);
        @(negedge aclk);
        bus.esdi_transfer_ack = 1'b0;
        ok = ok2;
    endtask

    task automatic run_frame(input logic [15:0] w, input logic rd, input logic [16:0] sf,
                             output logic [16:0] got, output int min_st, output int pulses,
                             output bit ok);
        logic b;
        int   st;
        bit   o;
        send_cmd(w, rd);
        got    = '0;
        min_st = 1000;
        pulses = 0;
        ok     = 1'b1;
        for (int i = 0; i < 17; i++) begin
            xfer_bit(1'b0, b, st, o);
            if (!o) begin ok = 1'b0; return; end
            got = {got[15:0], b};
            pulses++;
            if (st < min_st) min_st = st;
        end
        if (rd) begin
            for (int i = 0; i < 17; i++) begin
                xfer_bit(sf[16-i], b, st, o);
                if (!o) begin ok = 1'b0; return; end
                pulses++;
            end
        end
    endtask

    task automatic wait_rsp(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < LIMIT; i++) begin
            @(negedge aclk);
            if (bus.rsp_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic accept_rsp(input string tag);
        bus.rsp_ready = 1'b1;
        @(negedge aclk);
        bus.rsp_ready = 1'b0;
        check(tag, {bus.rsp_valid, bus.cmd_ready}, 2'b01);
    endtask

    initial begin
        logic [16:0] got;
        int          mst, pul, hi;
        bit          ok, hold_ok;
        logic        b;
        int          st;

        bus.cmd_valid          = 1'b0;
        bus.cmd_data           = '0;
        bus.cmd_read_status    = 1'b0;
        bus.rsp_ready          = 1'b0;
        bus.esdi_transfer_ack  = 1'b0;
        bus.esdi_confstat_data = 1'b0;

        // Reset state
        repeat (2) @(negedge aclk);
        check("rst_outputs", {bus.cmd_ready, bus.rsp_valid, bus.esdi_transfer_req,
                              bus.esdi_command_data, bus.rsp_timeout, bus.rsp_parity_err}, 6'b0);
        check("rst_status", bus.rsp_status, 16'h0000);
        aresetn = 1'b1;
        @(negedge aclk);
        check("rst_ready", bus.cmd_ready, 1'b1);

        // 1: all-zero command, no status
        run_frame(16'h0000, 1'b0, 17'h0, got, mst, pul, ok);
        check("t1_frame_ok", ok, 1'b1);
        check("t1_bits", got, 17'h00001);
        check("t1_pulses", pul, 17);
        check("t1_setup", (mst >= SETUP), 1'b1);
        wait_rsp(ok);
        check("t1_rsp_seen", ok, 1'b1);
        check("t1_rsp", {bus.rsp_timeout, bus.rsp_parity_err, bus.cmd_ready, bus.esdi_command_data}, 4'b0);
        check("t1_status", bus.rsp_status, 16'h0000);
        accept_rsp("t1_accept");

        // 2: 0x8001, checks bit order and setup time on changing data
        run_frame(16'h8001, 1'b0, 17'h0, got, mst, pul, ok);
        check("t2_frame_ok", ok, 1'b1);
        check("t2_bits", got, 17'h10003);
        check("t2_setup", (mst >= SETUP), 1'b1);
        wait_rsp(ok);
        check("t2_rsp", {ok, bus.rsp_timeout}, 2'b10);
        accept_rsp("t2_accept");

        // 3: status read with good parity
        run_frame(16'h1234, 1'b1, 17'h14B4B, got, mst, pul, ok);
        check("t3_frame_ok", ok, 1'b1);
        check("t3_bits", got, 17'h02468);
        check("t3_pulses", pul, 34);
        wait_rsp(ok);
        check("t3_rsp_seen", ok, 1'b1);
        check("t3_status", bus.rsp_status, 16'hA5A5);
        check("t3_flags", {bus.rsp_parity_err, bus.rsp_timeout}, 2'b00);
        accept_rsp("t3_accept");

        // 4: status read with bad parity
        run_frame(16'h1234, 1'b1, 17'h14B4A, got, mst, pul, ok);
        check("t4_frame_ok", ok, 1'b1);
        wait_rsp(ok);
        check("t4_status", bus.rsp_status, 16'hA5A5);
        check("t4_flags", {ok, bus.rsp_parity_err, bus.rsp_timeout}, 3'b110);
        accept_rsp("t4_accept");

        // 5: drive goes silent at bit 5
        send_cmd(16'h00FF, 1'b0);
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            xfer_bit(1'b0, b, st, hold_ok);
            if (!hold_ok) ok = 1'b0;
        end
        check("t5_prefix_ok", ok, 1'b1);
        wait_req(1'b1, ok);
        check("t5_req5", ok, 1'b1);
        hi = 1;
        for (int i = 0; i < 100; i++) begin
            @(negedge aclk);
            if (bus.esdi_transfer_req === 1'b1) hi++;
            else break;
        end
        check("t5_req_len", hi, TO);
        check("t5_rsp", {bus.rsp_valid, bus.rsp_timeout, bus.rsp_parity_err,
                         bus.esdi_transfer_req, bus.esdi_command_data}, 5'b11000);
        check("t5_status", bus.rsp_status, 16'h0000);
        accept_rsp("t5_accept");
        check("t5_flags_clr", bus.rsp_timeout, 1'b0);
        run_frame(16'h5A5A, 1'b0, 17'h0, got, mst, pul, ok);
        check("t5_next_ok", ok, 1'b1);
        check("t5_next_bits", got, 17'h0B4B5);
        wait_rsp(ok);
        check("t5_next_rsp", {ok, bus.rsp_timeout}, 2'b10);
        accept_rsp("t5_next_accept");

        // 6: reset during the status phase, then a held response
        send_cmd(16'h0F0F, 1'b1);
        ok = 1'b1;
        for (int i = 0; i < 17; i++) begin
            xfer_bit(1'b0, b, st, hold_ok);
            if (!hold_ok) ok = 1'b0;
        end
        wait_req(1'b1, hold_ok);
        check("t6_in_sreq", {ok, hold_ok}, 2'b11);
        aresetn               = 1'b0;
        bus.esdi_transfer_ack = 1'b0;
        @(negedge aclk);
        check("t6_rst_out", {bus.esdi_transfer_req, bus.esdi_command_data,
                             bus.rsp_valid, bus.cmd_ready}, 4'b0);
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        check("t6_ready", {bus.cmd_ready, bus.rsp_valid}, 2'b10);
        hold_ok = 1'b1;
        repeat (10) begin
            @(negedge aclk);
            if (bus.rsp_valid !== 1'b0 || bus.esdi_transfer_req !== 1'b0) hold_ok = 1'b0;
        end
        check("t6_no_rsp", hold_ok, 1'b1);

        run_frame(16'hC3C3, 1'b1, 17'h026AF, got, mst, pul, ok);
        check("t6_frame_ok", ok, 1'b1);
        check("t6_bits", got, 17'h18787);
        wait_rsp(ok);
        check("t6_rsp_seen", ok, 1'b1);
        hold_ok = 1'b1;
        repeat (8) begin
            @(negedge aclk);
            if (bus.rsp_valid !== 1'b1 || bus.cmd_ready !== 1'b0 ||
                bus.rsp_status !== 16'h1357 || bus.rsp_parity_err !== 1'b0) hold_ok = 1'b0;
        end
        check("t6_hold", hold_ok, 1'b1);
        accept_rsp("t6_accept");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
